// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer: debounces raw set/clear requests into clean,
// registered, never-overlapping S/R drive pulses for a clocked SR flip-flop.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst      - asynchronous active-high reset
//   set_req  - raw set request level (may bounce)
//   clr_req  - raw clear request level (may bounce)
//   S, R     - registered drives to the flip-flop, never high together
//   busy     - high whenever the sequencer is not idle
//   q_exp    - expected flip-flop Q after the last completed drive
//   conflict - one-cycle pulse per cycle both requests are sampled high
//
// Optional feature (macro SR_SET_PRIORITY_EN): when defined, both requests
// high count as a set request in IDLE and while qualifying a set. The
// conflict pulse is still raised. Undefined: both high never drives.
//
// Parameters:
//   DEBOUNCE_CYCLES - identical samples needed to qualify (1..2^CNT_W-1)
//   DRIVE_CYCLES    - cycles S or R stays high per command (1..2^CNT_W-1)
//   CNT_W           - width of the shared debounce/drive counter

module sr_drive_sequencer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DRIVE_CYCLES    = 2,
   parameter int CNT_W           = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   output logic S,
   output logic R,
   output logic busy,
   output logic q_exp,
   output logic conflict
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_QUAL  = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // QUAL holds the count of samples already seen, so the edge that
   // sees sample number DEBOUNCE_CYCLES is the one where cnt is one less.
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(DRIVE_CYCLES);

   logic [1:0]       state;
   logic [1:0]       state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             dir;
   logic             dir_n;
   logic             q_n;
   logic             conflict_n;
   logic             s_n;
   logic             r_n;
   logic             busy_n;

   logic             req_set;
   logic             req_clr;
   logic             req_both;
   logic             req_any;
   logic             keep;

   // Request decode. A "set" may include the both-high case when set
   // priority is enabled; a "clear" is always a lone clr_req.
`ifdef SR_SET_PRIORITY_EN
   assign req_set = set_req;
`else
   assign req_set = set_req & ~clr_req;
`endif
   assign req_clr  = clr_req & ~set_req;
   assign req_both = set_req & clr_req;
   assign req_any  = req_set | req_clr;

   // Qualification continues only while the latched direction is still
   // the one being requested; anything else aborts without a drive.
   assign keep = dir ? req_set : req_clr;

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      dir_n      = dir;
      q_n        = q_exp;
      conflict_n = 1'b0;

      unique case (state)
         ST_IDLE: begin
            conflict_n = req_both;
            if (req_any) begin
               dir_n = req_set;
               // A command that matches the current Q is redundant.
               if (req_set != q_exp) begin
                  cnt_n = CNT_ONE;
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_n = ST_DRIVE;
                  end else begin
                     state_n = ST_QUAL;
                  end
               end
            end
         end

         ST_QUAL: begin
            conflict_n = req_both;
            if (keep) begin
               if (cnt == DEB_LAST) begin
                  state_n = ST_DRIVE;
                  cnt_n   = CNT_ONE;
               end else begin
                  cnt_n = cnt + CNT_ONE;
               end
            end else begin
               state_n = ST_IDLE;
               cnt_n   = CNT_ZERO;
            end
         end

         ST_DRIVE: begin
            if (cnt == DRV_LAST) begin
               state_n = ST_GAP;
               cnt_n   = CNT_ZERO;
               q_n     = dir;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end

         ST_GAP: begin
            state_n = ST_IDLE;
            cnt_n   = CNT_ZERO;
         end

         default: begin
            state_n = ST_IDLE;
            cnt_n   = CNT_ZERO;
         end
      endcase

      // Drives derive from the next state, so they are registered and
      // exclusive by construction: dir selects exactly one of them.
      s_n    = (state_n == ST_DRIVE) &  dir_n;
      r_n    = (state_n == ST_DRIVE) & ~dir_n;
      busy_n = (state_n != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= CNT_ZERO;
         dir      <= 1'b0;
         S        <= 1'b0;
         R        <= 1'b0;
         busy     <= 1'b0;
         q_exp    <= 1'b0;
         conflict <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         dir      <= dir_n;
         S        <= s_n;
         R        <= r_n;
         busy     <= busy_n;
         q_exp    <= q_n;
         conflict <= conflict_n;
      end
   end

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// tb_sr_drive_sequencer: directed and random stimulus for
// sr_drive_sequencer, checked against a timeline reference model.

module tb_sr_drive_sequencer;

   localparam int DEB = 4;
   localparam int DRV = 2;

   logic clk;
   logic rst;
   logic set_req;
   logic clr_req;
   logic S;
   logic R;
   logic busy;
   logic q_exp;
   logic conflict;

   int compared;
   int mismatched;

   // Reference model: a timeline of drive windows rather than a state
   // machine. drv_start is the edge where S/R rise; the pulse lasts DRV
   // edges, the gap edge updates Q, and sampling resumes two edges later.
   int cyc;
   int run_len;
   int run_dir;
   int drv_start;
   int drv_dir;
   int free_at;
   bit m_q;
   bit exp_s;
   bit exp_r;
   bit exp_busy;
   bit exp_conf;

   sr_drive_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .DRIVE_CYCLES(DRV),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .set_req(set_req),
      .clr_req(clr_req),
      .S(S),
      .R(R),
      .busy(busy),
      .q_exp(q_exp),
      .conflict(conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b at edge %0d",
                tag, obs, expv, cyc);
      end
   endtask

   task automatic model_reset();
      run_len   = 0;
      run_dir   = 0;
      drv_start = -1000;
      drv_dir   = 0;
      free_at   = 0;
      m_q       = 1'b0;
   endtask

   task automatic model_edge(input bit s, input bit c);
      int want;
      bit in_drv;
      cyc++;
      exp_conf = 1'b0;
      if (cyc >= free_at) begin
         exp_conf = s & c;
         want = -1;
         if (s && !c) want = 1;
         if (c && !s) want = 0;
`ifdef SR_SET_PRIORITY_EN
         if (s && c) want = 1;
`endif
         if (run_len > 0) begin
            if (want == run_dir) run_len++;
            else run_len = 0;
         end else if (want >= 0 && want != int'(m_q)) begin
            run_dir = want;
            run_len = 1;
         end
         if (run_len == DEB) begin
            drv_start = cyc;
            drv_dir   = run_dir;
            free_at   = cyc + DRV + 2;
            run_len   = 0;
         end
      end
      if (cyc == drv_start + DRV) m_q = drv_dir[0];
      in_drv   = (cyc >= drv_start) && (cyc < drv_start + DRV);
      exp_s    = in_drv && (drv_dir == 1);
      exp_r    = in_drv && (drv_dir == 0);
      exp_busy = (run_len > 0) ||
                 ((cyc >= drv_start) && (cyc <= drv_start + DRV));
   endtask

   task automatic tick(input logic s, input logic c);
      set_req = s;
      clr_req = c;
      @(posedge clk);
      #1;
      model_edge(s, c);
      chk("S", S, exp_s);
      chk("R", R, exp_r);
      chk("busy", busy, exp_busy);
      chk("q_exp", q_exp, m_q);
      chk("conflict", conflict, exp_conf);
      chk("S_and_R", S & R, 1'b0);
   endtask

   task automatic check_all_low(input string tag);
      chk({tag, "_S"}, S, 1'b0);
      chk({tag, "_R"}, R, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_q_exp"}, q_exp, 1'b0);
      chk({tag, "_conflict"}, conflict, 1'b0);
   endtask

   task automatic do_reset();
      set_req = 1'b0;
      clr_req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_low("in_reset");
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
   endtask

   // set_req held from edge 0: S high after edges 3 and 4, gap at 5
   // with Q updated, idle from edge 6. Uses fixed expectations.
   task automatic set_pulse_fixed(input string tag);
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, 1'b0);
         chk({tag, "_fixS"}, S, (k == 3 || k == 4));
         chk({tag, "_fixR"}, R, 1'b0);
         chk({tag, "_fixq"}, q_exp, (k >= 5));
         chk({tag, "_fixbusy"}, busy, (k <= 5));
      end
   endtask

   initial begin
      logic [1:0] pat;
      compared   = 0;
      mismatched = 0;
      cyc        = 0;
      set_req    = 1'b0;
      clr_req    = 1'b0;
      rst        = 1'b1;
      model_reset();

      // 1: reset, then idle with no requests.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0);
         check_all_low("idle");
      end

      // 2: clean set command.
      set_pulse_fixed("set1");
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);

      // 5: redundant set while Q is already 1.
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 1'b0);
         chk("redundant_busy", busy, 1'b0);
         chk("redundant_S", S, 1'b0);
      end
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);

      // 3: short clear burst rejected, then a qualified clear.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      chk("burst_no_R", R, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
      chk("clr_R_rise", R, 1'b1);
      tick(1'b0, 1'b0);
      chk("clr_R_hold", R, 1'b1);
      tick(1'b0, 1'b0);
      chk("clr_gap_R", R, 1'b0);
      chk("clr_q", q_exp, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);

      // 4: both requests high together.
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b1);
         chk("both_R", R, 1'b0);
      end
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);

      // Random bouncing requests.
      pat = 2'b00;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) pat = 2'($urandom_range(0, 3));
         tick(pat[1], pat[0]);
      end
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);

      // 6: reset in the middle of a set drive.
      do_reset();
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
      chk("pre_abort_S", S, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_all_low("async_abort");
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
      set_pulse_fixed("set2");
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
